// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encodings, multiplier FSM states, flag bit
// positions and canonical quiet-NaN construction.
package fpu_pkg;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RUP = 2'd2;
    localparam logic [1:0] RM_RDN = 2'd3;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    localparam int MAX_W = 64;

    typedef enum logic [3:0] {
        StIdle,
        StUnpack,
        StSpecial,
        StNormA,
        StNormB,
        StMult,
        StAlign,
        StDenorm,
        StRound,
        StPack,
        StDone
    } state_e;

    // Sign 0, exponent all ones, mantissa MSB set; callers truncate to their width.
    function automatic logic [MAX_W-1:0] qnan(input int exp_w, input int man_w);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w+i] = 1'b1;
        end
        v[man_w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fpu_round.sv
// Rounding-increment decision shared by FPU arithmetic blocks.
module fpu_round
    import fpu_pkg::*;
(
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       r,
    input  logic       s,
    input  logic [1:0] rm,
    output logic       increment,
    output logic       inexact
);

    always_comb begin
        inexact   = g | r | s;
        increment = 1'b0;
        unique case (rm)
            RM_RNE:  increment = g & (r | s | lsb);
            RM_RTZ:  increment = 1'b0;
            RM_RUP:  increment = !sign & inexact;
            RM_RDN:  increment = sign & inexact;
            default: increment = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_mul_hs.sv
// Multi-cycle IEEE-754 multiplier with valid/ready handshakes on both sides,
// run-time rounding, subnormal support and exception flags.
module fp_mul_hs
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   input_a,
    input  logic [EXP_W+MAN_W:0]   input_b,
    input  logic [1:0]             rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   output_z,
    output logic [3:0]             flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int M    = MAN_W + 1;
    localparam int PW   = 2 * M;
    localparam int EW   = EXP_W + 2;
    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam int EMAX = 2**EXP_W - 1;

    localparam logic signed [EW-1:0] E_ONE   = EW'(1);
    localparam logic signed [EW-1:0] E_BIAS  = EW'(BIAS);
    localparam logic signed [EW-1:0] E_EMAX  = EW'(EMAX);
    localparam logic signed [EW-1:0] E_FLUSH = EW'(-(MAN_W + 2));
    localparam logic [W-1:0]         QNAN    = W'(qnan(EXP_W, MAN_W));

    state_e                 state, state_d;
    logic [W-1:0]           a_raw, b_raw;
    logic [1:0]             rm_q;
    logic                   z_s;
    logic signed [EW-1:0]   a_e, b_e, z_e;
    logic [M-1:0]           a_m, b_m, z_m;
    logic [PW-1:0]          prod;
    logic                   g_bit, r_bit, s_bit, inexact_q, special;

    logic [EXP_W-1:0]       a_exp, b_exp;
    logic [MAN_W-1:0]       a_man, b_man;
    logic                   a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
    logic                   a_zero, b_zero, a_sub, b_sub, is_special;
    logic [W-1:0]           spec_z, pack_z, inf_z, max_z;
    logic [3:0]             spec_f, pack_f;
    logic                   round_incr, round_inexact;
    logic [M:0]             z_m_inc;

    assign a_exp = a_raw[W-2 -: EXP_W];
    assign b_exp = b_raw[W-2 -: EXP_W];
    assign a_man = a_raw[MAN_W-1:0];
    assign b_man = b_raw[MAN_W-1:0];

    assign a_nan  = (&a_exp) && (|a_man);
    assign b_nan  = (&b_exp) && (|b_man);
    assign a_snan = a_nan && !a_man[MAN_W-1];
    assign b_snan = b_nan && !b_man[MAN_W-1];
    assign a_inf  = (&a_exp) && !(|a_man);
    assign b_inf  = (&b_exp) && !(|b_man);
    assign a_zero = !(|a_exp) && !(|a_man);
    assign b_zero = !(|b_exp) && !(|b_man);
    assign a_sub  = !(|a_exp) && (|a_man);
    assign b_sub  = !(|b_exp) && (|b_man);
    assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    assign inf_z = {z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign max_z = {z_s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

    assign in_ready = (state == StIdle) && !rst;

    fpu_round u_round (
        .sign      (z_s),
        .lsb       (z_m[0]),
        .g         (g_bit),
        .r         (r_bit),
        .s         (s_bit),
        .rm        (rm_q),
        .increment (round_incr),
        .inexact   (round_inexact)
    );

    assign z_m_inc = {1'b0, z_m} + {{M{1'b0}}, round_incr};

    always_comb begin
        spec_z = '0;
        spec_f = '0;
        if (a_nan || b_nan) begin
            spec_z = QNAN;
            spec_f[FLAG_INVALID] = a_snan || b_snan;
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_z = QNAN;
            spec_f[FLAG_INVALID] = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_z = inf_z;
        end else begin
            spec_z = {z_s, {(W-1){1'b0}}};
        end
    end

    always_comb begin
        pack_z = '0;
        pack_f = '0;
        if (z_e >= E_EMAX) begin
            pack_f[FLAG_OVERFLOW] = 1'b1;
            pack_f[FLAG_INEXACT]  = 1'b1;
            case (rm_q)
                RM_RTZ:  pack_z = max_z;
                RM_RUP:  pack_z = z_s ? max_z : inf_z;
                RM_RDN:  pack_z = z_s ? inf_z : max_z;
                default: pack_z = inf_z;
            endcase
        end else begin
            // No hidden bit here means the denorm pass left z_e at 1: encode subnormal/zero.
            pack_z = {z_s, z_m[M-1] ? z_e[EXP_W-1:0] : {EXP_W{1'b0}}, z_m[MAN_W-1:0]};
            pack_f[FLAG_UNDERFLOW] = !z_m[M-1] && inexact_q;
            pack_f[FLAG_INEXACT]   = inexact_q;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            StIdle:    if (in_valid) state_d = StUnpack;
            StUnpack:  state_d = StSpecial;
            StSpecial: state_d = is_special ? StPack : StNormA;
            StNormA:   if (a_m[M-1]) state_d = StNormB;
            StNormB:   if (b_m[M-1]) state_d = StMult;
            StMult:    state_d = StAlign;
            StAlign:   state_d = StDenorm;
            StDenorm:  if (!(z_e < E_ONE && z_e > E_FLUSH)) state_d = StRound;
            StRound:   state_d = StPack;
            StPack:    state_d = StDone;
            StDone:    if (out_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (rst) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            output_z  <= '0;
            flags     <= '0;
        end else begin
            case (state)
                StIdle: if (in_valid) begin
                    a_raw <= input_a;
                    b_raw <= input_b;
                    rm_q  <= rm;
                end
                StUnpack: begin
                    z_s     <= a_raw[W-1] ^ b_raw[W-1];
                    a_e     <= {2'b00, a_exp};
                    b_e     <= {2'b00, b_exp};
                    a_m     <= {1'b0, a_man};
                    b_m     <= {1'b0, b_man};
                    special <= 1'b0;
                end
                StSpecial: begin
                    if (is_special) begin
                        special  <= 1'b1;
                        output_z <= spec_z;
                        flags    <= spec_f;
                    end else begin
                        if (a_sub) a_e <= E_ONE;
                        else       a_m[M-1] <= 1'b1;
                        if (b_sub) b_e <= E_ONE;
                        else       b_m[M-1] <= 1'b1;
                    end
                end
                StNormA: if (!a_m[M-1]) begin
                    a_m <= a_m << 1;
                    a_e <= a_e - E_ONE;
                end
                StNormB: if (!b_m[M-1]) begin
                    b_m <= b_m << 1;
                    b_e <= b_e - E_ONE;
                end
                StMult: begin
                    prod <= {{M{1'b0}}, a_m} * {{M{1'b0}}, b_m};
                    z_e  <= a_e + b_e - E_BIAS;
                end
                StAlign: begin
                    if (prod[PW-1]) begin
                        z_m   <= prod[PW-1 -: M];
                        g_bit <= prod[M-1];
                        r_bit <= prod[M-2];
                        s_bit <= |prod[M-3:0];
                        z_e   <= z_e + E_ONE;
                    end else begin
                        z_m   <= prod[PW-2 -: M];
                        g_bit <= prod[M-2];
                        r_bit <= prod[M-3];
                        s_bit <= |prod[M-4:0];
                    end
                end
                StDenorm: begin
                    if (z_e < E_ONE && z_e > E_FLUSH) begin
                        z_m   <= z_m >> 1;
                        g_bit <= z_m[0];
                        r_bit <= g_bit;
                        s_bit <= s_bit | r_bit;
                        z_e   <= z_e + E_ONE;
                    end else if (z_e <= E_FLUSH) begin
                        z_m   <= '0;
                        g_bit <= 1'b0;
                        r_bit <= 1'b0;
                        s_bit <= 1'b1;
                        z_e   <= E_ONE;
                    end
                end
                StRound: begin
                    inexact_q <= round_inexact;
                    if (z_m_inc[M]) begin
                        z_m <= z_m_inc[M:1];
                        z_e <= z_e + E_ONE;
                    end else begin
                        z_m <= z_m_inc[M-1:0];
                    end
                end
                StPack: begin
                    out_valid <= 1'b1;
                    if (!special) begin
                        output_z <= pack_z;
                        flags    <= pack_f;
                    end
                end
                StDone: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_hs.sv
// Directed self-checking bench for the single-precision handshake multiplier.
module tb_fp_mul_hs;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic [1:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] output_z;
    logic [3:0]  flags;

    int total = 0;
    int bad   = 0;

    fp_mul_hs #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input_a   (input_a),
        .input_b   (input_b),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .output_z  (output_z),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Drives one operand pair and waits (bounded) for the result; lat=-1 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                          output logic [31:0] z, output logic [3:0] f, output int lat);
        input_a  = a;
        input_b  = b;
        rm       = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        z = output_z;
        f = flags;
        if (!out_valid) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        input_a = '0; input_b = '0; rm = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (output_z !== 32'h0) begin bad++; $display("FAIL reset_output_z: got %h want 00000000", output_z); end
        total++; if (flags !== 4'h0) begin bad++; $display("FAIL reset_flags: got %b want 0000", flags); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_hi: got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_lo: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] z; logic [3:0] f; int lat;
        run_op(32'h3FC00000, 32'h40000000, 2'd0, z, f, lat);
        total++; if (z !== 32'h40400000) begin bad++; $display("FAIL basic_z: got %h want 40400000", z); end
        total++; if (f !== 4'b0000) begin bad++; $display("FAIL basic_flags: got %b want 0000", f); end
        total++; if (lat !== 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
        run_op(32'h3F800001, 32'h3F800001, 2'd0, z, f, lat);
        total++; if (z !== 32'h3F800002) begin bad++; $display("FAIL inexact_rne_z: got %h want 3f800002", z); end
        total++; if (f !== 4'b0001) begin bad++; $display("FAIL inexact_rne_flags: got %b want 0001", f); end
        run_op(32'h3F800001, 32'h3F800001, 2'd2, z, f, lat);
        total++; if (z !== 32'h3F800003) begin bad++; $display("FAIL inexact_rup_z: got %h want 3f800003", z); end
        total++; if (f !== 4'b0001) begin bad++; $display("FAIL inexact_rup_flags: got %b want 0001", f); end
    endtask

    task automatic test_special();
        logic [31:0] z; logic [3:0] f; int lat;
        run_op(32'h7F800000, 32'h00000000, 2'd0, z, f, lat);
        total++; if (z !== 32'h7FC00000) begin bad++; $display("FAIL inf_zero_z: got %h want 7fc00000", z); end
        total++; if (f !== 4'b1000) begin bad++; $display("FAIL inf_zero_flags: got %b want 1000", f); end
        total++; if (lat < 1) begin bad++; $display("FAIL inf_zero_timeout: got %0d want >0", lat); end
        run_op(32'h7F800001, 32'h3F800000, 2'd0, z, f, lat);
        total++; if (z !== 32'h7FC00000) begin bad++; $display("FAIL snan_z: got %h want 7fc00000", z); end
        total++; if (f !== 4'b1000) begin bad++; $display("FAIL snan_flags: got %b want 1000", f); end
        run_op(32'h7FC00001, 32'h3F800000, 2'd0, z, f, lat);
        total++; if (z !== 32'h7FC00000) begin bad++; $display("FAIL qnan_z: got %h want 7fc00000", z); end
        total++; if (f !== 4'b0000) begin bad++; $display("FAIL qnan_flags: got %b want 0000", f); end
        run_op(32'hFF800000, 32'h40000000, 2'd0, z, f, lat);
        total++; if (z !== 32'hFF800000) begin bad++; $display("FAIL neg_inf_z: got %h want ff800000", z); end
        total++; if (f !== 4'b0000) begin bad++; $display("FAIL neg_inf_flags: got %b want 0000", f); end
        run_op(32'h80000000, 32'h3F800000, 2'd0, z, f, lat);
        total++; if (z !== 32'h80000000) begin bad++; $display("FAIL neg_zero_z: got %h want 80000000", z); end
    endtask

    task automatic test_overflow();
        logic [31:0] z; logic [3:0] f; int lat;
        run_op(32'h7F7FFFFF, 32'h40000000, 2'd0, z, f, lat);
        total++; if (z !== 32'h7F800000) begin bad++; $display("FAIL ovf_rne_z: got %h want 7f800000", z); end
        total++; if (f !== 4'b0101) begin bad++; $display("FAIL ovf_rne_flags: got %b want 0101", f); end
        run_op(32'h7F7FFFFF, 32'h40000000, 2'd1, z, f, lat);
        total++; if (z !== 32'h7F7FFFFF) begin bad++; $display("FAIL ovf_rtz_z: got %h want 7f7fffff", z); end
        total++; if (f !== 4'b0101) begin bad++; $display("FAIL ovf_rtz_flags: got %b want 0101", f); end
        run_op(32'hFF7FFFFF, 32'h40000000, 2'd3, z, f, lat);
        total++; if (z !== 32'hFF800000) begin bad++; $display("FAIL ovf_rdn_neg_z: got %h want ff800000", z); end
        total++; if (f !== 4'b0101) begin bad++; $display("FAIL ovf_rdn_neg_flags: got %b want 0101", f); end
        run_op(32'hFF7FFFFF, 32'h40000000, 2'd2, z, f, lat);
        total++; if (z !== 32'hFF7FFFFF) begin bad++; $display("FAIL ovf_rup_neg_z: got %h want ff7fffff", z); end
    endtask

    task automatic test_subnormal();
        logic [31:0] z; logic [3:0] f; int lat;
        run_op(32'h00800000, 32'h3F000000, 2'd0, z, f, lat);
        total++; if (z !== 32'h00400000) begin bad++; $display("FAIL sub_half_z: got %h want 00400000", z); end
        total++; if (f !== 4'b0000) begin bad++; $display("FAIL sub_half_flags: got %b want 0000", f); end
        run_op(32'h00000001, 32'h3F000000, 2'd0, z, f, lat);
        total++; if (z !== 32'h00000000) begin bad++; $display("FAIL sub_tiny_rne_z: got %h want 00000000", z); end
        total++; if (f !== 4'b0011) begin bad++; $display("FAIL sub_tiny_rne_flags: got %b want 0011", f); end
        total++; if (lat < 1) begin bad++; $display("FAIL sub_tiny_timeout: got %0d want >0", lat); end
        run_op(32'h00000001, 32'h3F000000, 2'd2, z, f, lat);
        total++; if (z !== 32'h00000001) begin bad++; $display("FAIL sub_tiny_rup_z: got %h want 00000001", z); end
        total++; if (f !== 4'b0011) begin bad++; $display("FAIL sub_tiny_rup_flags: got %b want 0011", f); end
    endtask

    task automatic test_backpressure();
        logic [31:0] z; logic [3:0] f; int lat; int n;
        out_ready = 1'b0;
        input_a = 32'h3FC00000; input_b = 32'h40000000; rm = 2'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout: got %b want 1", out_valid); end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1; input_a = 32'h3F800000; input_b = 32'h3F800000;
            end
            if (i == 4) in_valid = 1'b0;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            total++; if (output_z !== 32'h40400000) begin bad++; $display("FAIL bp_z[%0d]: got %h want 40400000", i, output_z); end
            total++; if (flags !== 4'b0000) begin bad++; $display("FAIL bp_flags[%0d]: got %b want 0000", i, flags); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        run_op(32'h40000000, 32'h40000000, 2'd0, z, f, lat);
        total++; if (z !== 32'h40800000) begin bad++; $display("FAIL bp_next_z: got %h want 40800000", z); end
        total++; if (lat !== 9) begin bad++; $display("FAIL bp_next_latency: got %0d want 9", lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] z; logic [3:0] f; int lat; bit seen;
        run_op(32'h3F800001, 32'h3F800001, 2'd0, z, f, lat);
        total++; if (f !== 4'b0001) begin bad++; $display("FAIL pre_reset_flags: got %b want 0001", f); end
        input_a = 32'h00000001; input_b = 32'h3F800000; rm = 2'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL mid_reset_flags: got %b want 0000", flags); end
        total++; if (output_z !== 32'h0) begin bad++; $display("FAIL mid_reset_z: got %h want 00000000", output_z); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_in_ready: got %b want 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_reset_aborted: got %b want 0", seen); end
        run_op(32'h3FC00000, 32'h40000000, 2'd0, z, f, lat);
        total++; if (z !== 32'h40400000) begin bad++; $display("FAIL post_reset_z: got %h want 40400000", z); end
        total++; if (f !== 4'b0000) begin bad++; $display("FAIL post_reset_flags: got %b want 0000", f); end
        total++; if (lat !== 9) begin bad++; $display("FAIL post_reset_latency: got %0d want 9", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_overflow();
        test_subnormal();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
